// File: rtl/lock_reg_pkg.sv
// Shared types and constants for the lockable configuration register arbiter.
package lock_reg_pkg;

  typedef enum logic [1:0] {
    LOCKED   = 2'd0,
    UNLOCKED = 2'd1,
    LOCKOUT  = 2'd2
  } unlock_state_t;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_DBG  = 1'b1;

  localparam logic [15:0] DEFAULT_UNLOCK_KEY = 16'hA5C3;

endpackage

// File: rtl/lock_reg_arbiter_if.sv
// Two-requester request/response bus: lane 0 is the host, lane 1 is debug.
interface lock_reg_arbiter_if #(
  parameter int DW = 16,
  parameter int AW = 2
);
  // A request transfers on the cycle where req_valid[i] & req_ready[i]; the
  // requester holds its fields stable while valid is low-ready. The response
  // is a one-cycle rsp_valid[i] pulse exactly one cycle after the transfer,
  // with rsp_err/rsp_rdata qualified by it. No backpressure on responses.
  logic [1:0]      req_valid;
  logic [1:0]      req_ready;
  logic [1:0]      req_we;
  logic [2*AW-1:0] req_addr;
  logic [2*DW-1:0] req_wdata;
  logic [1:0]      rsp_valid;
  logic            rsp_err;
  logic [DW-1:0]   rsp_rdata;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata
  );
endinterface

// File: rtl/debug_unlock_fsm.sv
// Debug authentication: key compare, bad-key lockout timer and session flag.
module debug_unlock_fsm
  import lock_reg_pkg::*;
#(
  parameter int            DW             = 16,
  parameter logic [DW-1:0] UNLOCK_KEY     = DW'(DEFAULT_UNLOCK_KEY),
  parameter int            LOCKOUT_CYCLES = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          key_valid,
  input  logic [DW-1:0] key,
  input  logic          relock,
  output logic          debug_unlocked,
  output unlock_state_t state
);

  localparam int CW = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;

  unlock_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= LOCKED;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      LOCKED: begin
        if (key_valid) begin
          if (key == UNLOCK_KEY) begin
            state_d = UNLOCKED;
          end else begin
            state_d = LOCKOUT;
            cnt_d   = CW'(LOCKOUT_CYCLES - 1);
          end
        end
      end
      // Counter runs LOCKOUT_CYCLES-1 down to 0, one state-cycle per value.
      LOCKOUT: begin
        if (cnt_q == '0) state_d = LOCKED;
        else             cnt_d   = cnt_q - CW'(1);
      end
      UNLOCKED: begin
        if (relock) state_d = LOCKED;
      end
      default: state_d = LOCKED;
    endcase
  end

  assign debug_unlocked = (state_q == UNLOCKED);
  assign state          = state_q;

endmodule

// File: rtl/lock_reg_arbiter.sv
// Round-robin host/debug access to a bank of sticky-lockable config registers.
module lock_reg_arbiter
  import lock_reg_pkg::*;
#(
  parameter int            NREGS          = 4,
  parameter int            DW             = 16,
  parameter int            AW             = 2,
  parameter logic [DW-1:0] UNLOCK_KEY     = DW'(DEFAULT_UNLOCK_KEY),
  parameter int            LOCKOUT_CYCLES = 8
) (
  input  logic                clk,
  input  logic                resetn,
  lock_reg_arbiter_if.slave   bus,
  input  logic [NREGS-1:0]    lock_set,
  output logic [NREGS-1:0]    lock_q,
  input  logic                scan_mode,
  input  logic                dbg_key_valid,
  input  logic [DW-1:0]       dbg_key,
  input  logic                dbg_relock,
  output logic                debug_unlocked,
  output logic [NREGS*DW-1:0] reg_q
);

  localparam logic [AW:0] NREGS_W = (AW+1)'(NREGS);

  logic [DW-1:0] regs [NREGS];
  logic          rr_last;
  logic          gnt_any;
  logic          gnt_id;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          addr_ok;
  logic          wr_perm;
  logic          rsp_err_d;
  logic [DW-1:0] rd_val;
  logic [NREGS-1:0] lock_eff;
  unlock_state_t unlock_state;

  // Test access must never open a write path, so scan_mode is deliberately unused.
  logic unused_scan;
  assign unused_scan = scan_mode ^ (unlock_state == LOCKOUT);

  debug_unlock_fsm #(
    .DW             (DW),
    .UNLOCK_KEY     (UNLOCK_KEY),
    .LOCKOUT_CYCLES (LOCKOUT_CYCLES)
  ) u_unlock (
    .clk            (clk),
    .resetn         (resetn),
    .key_valid      (dbg_key_valid),
    .key            (dbg_key),
    .relock         (dbg_relock),
    .debug_unlocked (debug_unlocked),
    .state          (unlock_state)
  );

  // Grant selection; no grant is offered while reset is held.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = REQ_HOST;
    if (resetn) begin
      case (bus.req_valid)
        2'b01:   begin gnt_any = 1'b1; gnt_id = REQ_HOST; end
        2'b10:   begin gnt_any = 1'b1; gnt_id = REQ_DBG;  end
        2'b11:   begin gnt_any = 1'b1; gnt_id = ~rr_last; end
        default: begin gnt_any = 1'b0; gnt_id = REQ_HOST; end
      endcase
    end
  end

  assign bus.req_ready = gnt_any ? ((gnt_id == REQ_DBG) ? 2'b10 : 2'b01) : 2'b00;

  assign sel_we    = (gnt_id == REQ_DBG) ? bus.req_we[1]           : bus.req_we[0];
  assign sel_addr  = (gnt_id == REQ_DBG) ? bus.req_addr[2*AW-1:AW] : bus.req_addr[AW-1:0];
  assign sel_wdata = (gnt_id == REQ_DBG) ? bus.req_wdata[2*DW-1:DW] : bus.req_wdata[DW-1:0];
  assign addr_ok   = ({1'b0, sel_addr} < NREGS_W);
  assign lock_eff  = lock_q | lock_set;

  // A same-cycle lock_set already counts as locked; only a live debug session bypasses.
  always_comb begin
    rd_val  = '0;
    wr_perm = 1'b0;
    for (int i = 0; i < NREGS; i++) begin
      if (sel_addr == AW'(i)) begin
        rd_val  = regs[i];
        wr_perm = !lock_eff[i] || ((gnt_id == REQ_DBG) && debug_unlocked);
      end
    end
  end

  assign rsp_err_d = !addr_ok || (sel_we && !wr_perm);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      regs          <= '{default: '0};
      lock_q        <= '0;
      rr_last       <= REQ_HOST;
      bus.rsp_valid <= '0;
      bus.rsp_err   <= 1'b0;
      bus.rsp_rdata <= '0;
    end else begin
      lock_q <= lock_eff;
      if (gnt_any) rr_last <= gnt_id;
      for (int i = 0; i < NREGS; i++) begin
        if (gnt_any && sel_we && addr_ok && wr_perm && (sel_addr == AW'(i)))
          regs[i] <= sel_wdata;
      end
      bus.rsp_valid <= bus.req_ready;
      bus.rsp_err   <= gnt_any && rsp_err_d;
      bus.rsp_rdata <= (gnt_any && !sel_we && addr_ok) ? rd_val : '0;
    end
  end

  for (genvar g = 0; g < NREGS; g++) begin : g_regq
    assign reg_q[g*DW +: DW] = regs[g];
  end

endmodule
